ksa_addsub_pipe: RTL and testbench
==================================

# ksa_addsub_pipe

Parametrised, pipelined Kogge-Stone add/subtract unit for the RISC CPU execute stage. It generalises the fixed 32-bit combinational subtractor in three ways:
- configurable width and pipeline depth;
- four operations (ADD, SUB, ADDC, SUBB);
- a valid/ready handshake with backpressure and optional status flags.

It sits between the operand-issue logic and the writeback/branch-compare logic.

## Interface
Parameters:
- WIDTH, 32, operand width; power of two, 8..64.
- STAGES, 2, register stages = latency in cycles; 1..log2(WIDTH).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input operation valid.
- o_ready  out  1  unit accepts an input this cycle.
- i_op  in  2  operation: 0 ADD, 1 SUB, 2 ADDC, 3 SUBB.
- i_cin  in  1  carry-in for ADDC/SUBB (SUBB: 1 = no borrow); ignored for ADD/SUB.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_s  out  WIDTH  sum/difference.
- o_carry  out  1  carry out of MSB; for SUB, 1 = no borrow (A >= B unsigned).
- o_ovf  out  1  signed overflow.
- o_zero  out  1  o_s == 0.
- o_neg  out  1  o_s[WIDTH-1].

## Operation
Operand and carry-in selection per op, with effective carry-in c0:
- ADD: b' = i_b, c0 = 0.
- SUB: b' = ~i_b, c0 = 1.
- ADDC: b' = i_b, c0 = i_cin.
- SUBB: b' = ~i_b, c0 = i_cin.

Datapath:
- Layer 0: bitwise p = a ^ b', g = a & b'. The carry-in is folded into bit 0 as a grey cell.
- Then L = log2(WIDTH) Kogge-Stone prefix levels. Level k combines span 2^(k-1): black cells above the span, grey cells below it.
- Sum: o_s[0] = p[0] ^ c0; o_s[i] = p[i] ^ G[i-1].
- o_carry = G[WIDTH-1].
- o_ovf = carry into MSB ^ carry out of MSB.

Flags and results are computed combinationally in the last stage and registered with o_s.

Pipelining:
- Internal register boundaries follow prefix level ceil(j*L/STAGES), for j = 1..STAGES-1.
- The final register stage holds o_s and the flags.
- Each stage register carries a valid bit plus p, partial g/G and c0.

Handshake:
- Global enable en = ~o_valid | i_ready. All stages advance together when en is high.
- o_ready = en.
- An input is accepted when i_valid & o_ready.
- A bubble (valid 0) propagates like data.

Boundary conditions:
- While o_valid & ~i_ready, all stage registers and outputs hold, and o_s/flags stay stable.
- Simultaneous accept and emit is allowed every cycle, giving throughput 1/cycle.
- The unit never drops, duplicates or reorders operations.

Reset:
- All valid bits 0, o_s 0, all flags 0, o_valid 0, o_ready 1.
- Reset asserted mid-operation discards every in-flight operation immediately, since it is asynchronous.

Width rules:
- Arithmetic is modulo 2^WIDTH.
- No internal width beyond WIDTH+1 (the carry).

## Timing
- Latency: STAGES cycles from the accept edge to o_valid high, when unstalled.
- With STAGES = 1, the result is registered one cycle after accept.
- Stall: each cycle of ~i_ready while o_valid adds one cycle to every in-flight operation.
- o_ready is combinational from o_valid and i_ready only. There is no path from i_valid or the operands to o_ready.
- Critical path: ceil(L/STAGES) prefix levels plus the sum XOR.

## Configuration
KSA_FLAGS_EN:
- Defined: o_ovf, o_zero and o_neg are computed and registered as described.
- Undefined: o_ovf, o_zero and o_neg are tied to 0, and no flag logic or registers exist.
- o_carry and o_s are unaffected in both cases.

## Structure
- Package ksa_pkg holds:
  - the op enum (OP_ADD, OP_SUB, OP_ADDC, OP_SUBB);
  - the function computing the level-to-stage map from WIDTH/STAGES;
  - the constant LOG2 helper.
- One sub-module, ksa_prefix_cell. It is a generate-parametrised black/grey cell with inputs (p_hi, g_hi, p_lo, g_lo) and outputs (g, p); the p output is unused in grey mode.
- All prefix levels are generated in loops. No hand-unrolled cells.

## Test plan
All scenarios use WIDTH=32, STAGES=2, KSA_FLAGS_EN defined.
- SUB 5 - 3 -> o_s=2, carry=1, ovf=0, zero=0, neg=0; o_valid exactly 2 cycles after accept.
- SUB 3 - 5 -> o_s=0xFFFFFFFE, carry=0, neg=1, ovf=0.
- ADD 0x7FFFFFFF + 1 -> o_s=0x80000000, ovf=1, carry=0, neg=1.
- ADDC 0xFFFFFFFF + 0 with cin=1 -> o_s=0, carry=1, zero=1. Also SUBB 0 - 0 with cin=0 -> o_s=0xFFFFFFFF, carry=0.
- Backpressure: ops ADD k+k for k=1..4 back-to-back, i_ready low for 3 cycles when the first result is valid -> o_ready low during the stall, o_s held at 2, then results 2, 4, 6, 8 in order with none lost or duplicated.
- Async reset asserted with 2 ops in flight -> o_valid falls immediately and o_s=0. After release, a new SUB 9 - 9 -> o_s=0, zero=1, carry=1.

Source files
------------

// File: rtl/ksa_pkg.sv
// Shared types and elaboration-time helpers for the Kogge-Stone add/sub unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ksa_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_ADDC = 2'd2,
    OP_SUBB = 2'd3
  } op_e;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int log2c(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Pipeline stage that evaluates prefix level lvl (level 0 = operand layer).
  // Register boundary j sits after level ceil(j*L/stages), j = 1..stages-1.
  function automatic int level_stage(input int lvl, input int width, input int stages);
    int l;
    int st;
    l  = log2c(width);
    st = 0;
    for (int j = 1; j < stages; j++) begin
      if (((j * l) + stages - 1) / stages < lvl) begin
        st = st + 1;
      end
    end
    return st;
  endfunction

endpackage

// File: rtl/ksa_prefix_cell.sv
// Kogge-Stone prefix cell: black (group g and p) or grey (group g only).
// Latency: combinational.
// Backpressure: none, pure logic.
module ksa_prefix_cell #(
  parameter bit BLACK = 1'b1
) (
  input  logic p_hi,
  input  logic g_hi,
  input  logic p_lo,
  input  logic g_lo,
  output logic g,
  output logic p
);

  assign g = g_hi | (p_hi & g_lo);

  generate
    if (BLACK) begin : g_black
      assign p = p_hi & p_lo;
    end else begin : g_grey
      // Lower group already resolves to a carry, so its propagate is irrelevant.
      logic unused_p_lo;
      assign unused_p_lo = p_lo;
      assign p           = p_hi;
    end
  endgenerate

endmodule

// File: rtl/ksa_addsub_pipe.sv
// Pipelined Kogge-Stone ADD/SUB/ADDC/SUBB unit; status flags built only with KSA_FLAGS_EN.
// Latency: STAGES cycles from accept to o_valid; throughput one op per cycle.
// Backpressure: single global enable; whole pipe freezes while o_valid & ~i_ready.
module ksa_addsub_pipe
  import ksa_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic             i_cin,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_carry,
  output logic             o_ovf,
  output logic             o_zero,
  output logic             o_neg
);

  localparam int L = log2c(WIDTH);

  // Bubbles advance with data, so the only stall is a held output.
  logic en;
  assign en      = ~o_valid | i_ready;
  assign o_ready = en;

  logic [WIDTH-1:0] b_eff;
  logic             c0_in;

  // Operand inversion and effective carry-in per operation.
  always_comb begin
    b_eff = i_b;
    c0_in = 1'b0;
    case (op_e'(i_op))
      OP_ADD:  begin b_eff = i_b;  c0_in = 1'b0;  end
      OP_SUB:  begin b_eff = ~i_b; c0_in = 1'b1;  end
      OP_ADDC: begin b_eff = i_b;  c0_in = i_cin; end
      OP_SUBB: begin b_eff = ~i_b; c0_in = i_cin; end
      default: begin b_eff = i_b;  c0_in = 1'b0;  end
    endcase
  end

  // Layer 0: bitwise propagate/generate, carry-in merged into bit 0.
  logic [WIDTH-1:0] l0_p;
  logic [WIDTH-1:0] l0_g;
  logic [WIDTH-1:0] l0_gf;
  logic             unused_cin_p;

  assign l0_p               = i_a ^ b_eff;
  assign l0_g               = i_a & b_eff;
  assign l0_gf[WIDTH-1:1]   = l0_g[WIDTH-1:1];

  ksa_prefix_cell #(.BLACK(1'b0)) u_cin_cell (
    .p_hi (l0_p[0]),
    .g_hi (l0_g[0]),
    .p_lo (1'b0),
    .g_lo (c0_in),
    .g    (l0_gf[0]),
    .p    (unused_cin_p)
  );

  genvar k, i;
  generate
    for (k = 1; k <= L; k = k + 1) begin : g_lvl
      localparam int SPAN = 1 << (k - 1);
      localparam bit BND  = (level_stage(k, WIDTH, STAGES) != level_stage(k - 1, WIDTH, STAGES));

      // Previous level, before any stage register.
      logic [WIDTH-1:0] pv_g, pv_p, pv_s0;
      logic             pv_c0, pv_v;
      // Inputs of this level (registered when a stage boundary precedes it).
      logic [WIDTH-1:0] gi, pi, s0i;
      logic             c0i, vi;
      // Combinational outputs of this level.
      logic [WIDTH-1:0] go, po;

      if (k == 1) begin : g_src0
        assign pv_g  = l0_gf;
        assign pv_p  = l0_p;
        assign pv_s0 = l0_p;
        assign pv_c0 = c0_in;
        assign pv_v  = i_valid;
      end else begin : g_srcn
        assign pv_g  = g_lvl[k-1].go;
        assign pv_p  = g_lvl[k-1].po;
        assign pv_s0 = g_lvl[k-1].s0i;
        assign pv_c0 = g_lvl[k-1].c0i;
        assign pv_v  = g_lvl[k-1].vi;
      end

      if (BND) begin : g_reg
        // Stage boundary: capture partial prefix state plus sideband on enable.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) begin
            gi  <= '0;
            pi  <= '0;
            s0i <= '0;
            c0i <= 1'b0;
            vi  <= 1'b0;
          end else if (en) begin
            gi  <= pv_g;
            pi  <= pv_p;
            s0i <= pv_s0;
            c0i <= pv_c0;
            vi  <= pv_v;
          end
        end
      end else begin : g_wire
        assign gi  = pv_g;
        assign pi  = pv_p;
        assign s0i = pv_s0;
        assign c0i = pv_c0;
        assign vi  = pv_v;
      end

      for (i = 0; i < WIDTH; i = i + 1) begin : g_bit
        if (i < SPAN) begin : g_pass
          assign go[i] = gi[i];
          assign po[i] = pi[i];
        end else begin : g_cell
          ksa_prefix_cell #(.BLACK(i >= 2 * SPAN)) u_cell (
            .p_hi (pi[i]),
            .g_hi (gi[i]),
            .p_lo (pi[i-SPAN]),
            .g_lo (gi[i-SPAN]),
            .g    (go[i]),
            .p    (po[i])
          );
        end
      end
    end
  endgenerate

  // Final group propagate is never needed once every carry is resolved.
  logic [WIDTH-1:0] unused_po;
  assign unused_po = g_lvl[L].po;

  logic [WIDTH-1:0] g_fin;
  logic [WIDTH-1:0] s_fin;
  assign g_fin = g_lvl[L].go;
  assign s_fin = g_lvl[L].s0i ^ {g_fin[WIDTH-2:0], g_lvl[L].c0i};

  // Output stage: result, carry and valid advance together on enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_s     <= '0;
      o_carry <= 1'b0;
    end else if (en) begin
      o_valid <= g_lvl[L].vi;
      o_s     <= s_fin;
      o_carry <= g_fin[WIDTH-1];
    end
  end

`ifdef KSA_FLAGS_EN
  // Status flags registered alongside the result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ovf  <= 1'b0;
      o_zero <= 1'b0;
      o_neg  <= 1'b0;
    end else if (en) begin
      o_ovf  <= g_fin[WIDTH-1] ^ g_fin[WIDTH-2];
      o_zero <= (s_fin == '0);
      o_neg  <= s_fin[WIDTH-1];
    end
  end
`else
  assign o_ovf  = 1'b0;
  assign o_zero = 1'b0;
  assign o_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_ksa_addsub_pipe.sv
// Self-checking bench for ksa_addsub_pipe (WIDTH=32, STAGES=2).
// Latency: directed ops check exact STAGES-cycle latency; random phase uses a scoreboard.
// Backpressure: directed stall plus randomized i_ready exercise hold and ordering.
module tb_ksa_addsub_pipe;
  import ksa_pkg::*;

  localparam int W  = 32;
  localparam int ST = 2;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [1:0]    i_op;
  logic          i_cin;
  logic [W-1:0]  i_a;
  logic [W-1:0]  i_b;
  logic          o_valid;
  logic          i_ready;
  logic [W-1:0]  o_s;
  logic          o_carry;
  logic          o_ovf;
  logic          o_zero;
  logic          o_neg;

  int n_assert;
  int n_fail;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } res_t;

  res_t q[$];

  ksa_addsub_pipe #(.WIDTH(W), .STAGES(ST)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_cin   (i_cin),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_s     (o_s),
    .o_carry (o_carry),
    .o_ovf   (o_ovf),
    .o_zero  (o_zero),
    .o_neg   (o_neg)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference: plain wide arithmetic and the two's-complement sign rule.
  function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic cin);
    logic [W-1:0] bb;
    logic         c0;
    logic [W:0]   sum;
    res_t         r;
    bb  = (op == OP_SUB || op == OP_SUBB) ? ~b : b;
    c0  = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : cin;
    sum = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
    r.s = sum[W-1:0];
    r.c = sum[W];
`ifdef KSA_FLAGS_EN
    r.v = (a[W-1] == bb[W-1]) && (r.s[W-1] != a[W-1]);
    r.z = (r.s == '0);
    r.n = r.s[W-1];
`else
    r.v = 1'b0;
    r.z = 1'b0;
    r.n = 1'b0;
`endif
    return r;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = 32'h8000_0000;
      3:       v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input res_t e);
    chk({tag, ".s"},    64'(o_s),     64'(e.s));
    chk({tag, ".c"},    64'(o_carry), 64'(e.c));
    chk({tag, ".ovf"},  64'(o_ovf),   64'(e.v));
    chk({tag, ".zero"}, 64'(o_zero),  64'(e.z));
    chk({tag, ".neg"},  64'(o_neg),   64'(e.n));
  endtask

  // One isolated op: exact latency, literal sum/carry, model for all fields.
  task automatic single(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] exp_s, input logic exp_c);
    int cnt;
    @(negedge i_clk);
    i_op = op; i_a = a; i_b = b; i_cin = cin; i_valid = 1'b1; i_ready = 1'b1;
    #1 chk({tag, ".rdy"}, 64'(o_ready), 64'(1));
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    cnt = 1;
    while (!o_valid && cnt < 10) begin
      @(posedge i_clk); #1;
      cnt++;
    end
    chk({tag, ".lat"},   64'(cnt),     64'(ST));
    chk({tag, ".s_lit"}, 64'(o_s),     64'(exp_s));
    chk({tag, ".c_lit"}, 64'(o_carry), 64'(exp_c));
    chk_res(tag, model(op, a, b, cin));
    @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] got[$];
    logic         acc;
    logic         exp_rdy;
    int           cur;
    res_t         e;

    n_assert = 0;
    n_fail   = 0;
    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b1;
    i_op     = 2'd0;
    i_cin    = 1'b0;
    i_a      = '0;
    i_b      = '0;

    // Reset state.
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst.vld",   64'(o_valid), 64'(0));
    chk("rst.s",     64'(o_s),     64'(0));
    chk("rst.rdy",   64'(o_ready), 64'(1));
    chk("rst.c",     64'(o_carry), 64'(0));
    chk("rst.ovf",   64'(o_ovf),   64'(0));
    chk("rst.zero",  64'(o_zero),  64'(0));
    chk("rst.neg",   64'(o_neg),   64'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Directed ops.
    single("sub_5_3",  OP_SUB,  32'd5,         32'd3, 1'b0, 32'd2,         1'b1);
    single("sub_3_5",  OP_SUB,  32'd3,         32'd5, 1'b0, 32'hFFFF_FFFE, 1'b0);
    single("add_ovf",  OP_ADD,  32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0);
    single("addc_wrap",OP_ADDC, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0,         1'b1);
    single("subb_0_0", OP_SUBB, 32'd0,         32'd0, 1'b0, 32'hFFFF_FFFF, 1'b0);

    // Backpressure: ADD k+k for k=1..4, stall 3 cycles on first result.
    @(negedge i_clk);
    i_ready = 1'b1; i_valid = 1'b1; i_op = OP_ADD; i_cin = 1'b0; i_a = 32'd1; i_b = 32'd1;
    @(posedge i_clk); #1;
    i_a = 32'd2; i_b = 32'd2;
    @(posedge i_clk); #1;
    chk("bp.first_vld", 64'(o_valid), 64'(1));
    chk("bp.first_s",   64'(o_s),     64'(2));
    i_ready = 1'b0; i_a = 32'd3; i_b = 32'd3;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp.rdy_low",  64'(o_ready), 64'(0));
      chk("bp.hold_s",   64'(o_s),     64'(2));
      chk("bp.hold_vld", 64'(o_valid), 64'(1));
      @(posedge i_clk); #1;
    end
    i_ready = 1'b1;
    cur = 3;
    repeat (12) begin
      #1;
      if (o_valid) got.push_back(o_s);
      acc = i_valid && o_ready;
      @(posedge i_clk); #1;
      if (acc) begin
        cur++;
        if (cur <= 4) begin
          i_a = W'(cur); i_b = W'(cur);
        end else begin
          i_valid = 1'b0;
        end
      end
    end
    chk("bp.count", 64'(got.size()), 64'(4));
    for (int j = 0; j < 4 && j < got.size(); j++) begin
      chk("bp.order", 64'(got[j]), 64'(2 * (j + 1)));
    end

    // Async reset with two ops in flight.
    @(negedge i_clk);
    i_valid = 1'b1; i_op = OP_ADD; i_a = 32'd10; i_b = 32'd20;
    @(posedge i_clk); #1;
    i_a = 32'd30; i_b = 32'd40;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    chk("arst.pre_vld", 64'(o_valid), 64'(1));
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst.vld",  64'(o_valid), 64'(0));
    chk("arst.s",    64'(o_s),     64'(0));
    chk("arst.rdy",  64'(o_ready), 64'(1));
    chk("arst.c",    64'(o_carry), 64'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (4) @(posedge i_clk);
    #1 chk("arst.flushed", 64'(o_valid), 64'(0));
    single("sub_9_9", OP_SUB, 32'd9, 32'd9, 1'b0, 32'd0, 1'b1);

    // Randomized traffic against the scoreboard.
    for (int n = 0; n < 400; n++) begin
      @(negedge i_clk);
      i_valid = ($urandom_range(0, 9) < 7);
      i_ready = ($urandom_range(0, 3) != 0);
      i_op    = 2'($urandom_range(0, 3));
      i_a     = pick();
      i_b     = pick();
      i_cin   = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = !o_valid || i_ready;
      chk("rnd.rdy", 64'(o_ready), 64'(exp_rdy));
      if (o_valid && i_ready) begin
        chk("rnd.expected_pending", 64'(q.size() != 0), 64'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          chk_res("rnd", e);
        end
      end
      if (i_valid && exp_rdy) q.push_back(model(i_op, i_a, i_b, i_cin));
    end

    // Drain remaining results.
    @(negedge i_clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int d = 0; d < 20; d++) begin
      #1;
      if (o_valid) begin
        chk("drain.expected_pending", 64'(q.size() != 0), 64'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          chk_res("drain", e);
        end
      end
      @(negedge i_clk);
    end
    chk("drain.empty", 64'(q.size()), 64'(0));
    chk("drain.vld",   64'(o_valid),  64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
